// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared board geometry, direction/state enums and cell indexing for Connect Four
package connect4_pkg;

  localparam int ROWS        = 6;
  localparam int COLS        = 7;
  localparam int NUM_CELLS   = ROWS * COLS;
  localparam int NUM_WINDOWS = NUM_CELLS * 4;

  typedef enum logic [1:0] {
    DIR_H   = 2'd0,
    DIR_V   = 2'd1,
    DIR_DUR = 2'd2,
    DIR_DUL = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cell_index(input int row, input int col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/connect4_win_scanner_win_window_check.sv
// rtl/connect4_win_scanner_win_window_check.sv - combinational test of one four-cell window on one colour board
module win_window_check
  import connect4_pkg::*;
(
  input  logic [2:0]           anchor_row,
  input  logic [2:0]           anchor_col,
  input  dir_t                 dir,
  input  logic [NUM_CELLS-1:0] board,
  output logic                 in_bounds,
  output logic                 match
);

  // Widened board so off-board indices read as 0 instead of running past the vector.
  logic [127:0] board_ext;
  logic [3:0]   cell_set;

  assign board_ext = {{(128 - NUM_CELLS){1'b0}}, board};

  always_comb begin
    in_bounds = 1'b0;
    case (dir)
      DIR_H:   in_bounds = (anchor_col <= 3'(COLS - 4));
      DIR_V:   in_bounds = (anchor_row <= 3'(ROWS - 4));
      DIR_DUR: in_bounds = (anchor_row <= 3'(ROWS - 4)) && (anchor_col <= 3'(COLS - 4));
      DIR_DUL: in_bounds = (anchor_row <= 3'(ROWS - 4)) && (anchor_col >= 3'd3);
      default: in_bounds = 1'b0;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_cell
    logic [3:0] r;
    logic [3:0] c;
    logic [6:0] idx;
    assign r   = {1'b0, anchor_row} + ((dir == DIR_H) ? 4'd0 : 4'(i));
    assign c   = (dir == DIR_V)   ? {1'b0, anchor_col} :
                 (dir == DIR_DUL) ? {1'b0, anchor_col} - 4'(i) :
                                    {1'b0, anchor_col} + 4'(i);
    assign idx = 7'(cell_index(int'(r), int'(c)));
    assign cell_set[i] = board_ext[idx];
  end

  assign match = in_bounds & (&cell_set);

endmodule

// File: rtl/connect4_win_scanner.sv
// rtl/connect4_win_scanner.sv - sequential win/draw scanner, one four-cell window per frame_clk cycle
// Optional macro WIN_SCAN_DRAW_EN enables the full-board draw output; otherwise draw is tied low.
module connect4_win_scanner
  import connect4_pkg::*;
(
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [NUM_CELLS-1:0] red_cells,
  input  logic [NUM_CELLS-1:0] black_cells,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 red_win,
  output logic                 black_win,
  output logic                 draw,
  output logic [2:0]           win_row,
  output logic [2:0]           win_col,
  output logic [1:0]           win_dir
);

  state_t               state;
  logic [7:0]           win_cnt;
  logic [NUM_CELLS-1:0] red_snap;
  logic [NUM_CELLS-1:0] black_snap;

  logic [5:0] anchor;
  logic [2:0] anchor_row;
  logic [2:0] anchor_col;
  dir_t       dir;
  logic       red_in_bounds, red_match;
  logic       black_in_bounds, black_match;
  logic       any_match;
  logic       draw_next;

  // Window k = anchor*4 + dir, so the counter splits directly into anchor and direction.
  assign anchor     = win_cnt[7:2];
  assign anchor_row = 3'(anchor / 6'd7);
  assign anchor_col = 3'(anchor % 6'd7);
  assign dir        = dir_t'(win_cnt[1:0]);

  win_window_check u_red_check (
    .anchor_row (anchor_row),
    .anchor_col (anchor_col),
    .dir        (dir),
    .board      (red_snap),
    .in_bounds  (red_in_bounds),
    .match      (red_match)
  );

  win_window_check u_black_check (
    .anchor_row (anchor_row),
    .anchor_col (anchor_col),
    .dir        (dir),
    .board      (black_snap),
    .in_bounds  (black_in_bounds),
    .match      (black_match)
  );

  assign any_match = red_in_bounds & black_in_bounds & (red_match | black_match);

`ifdef WIN_SCAN_DRAW_EN
  assign draw_next = &(red_snap | black_snap);
`else
  assign draw_next = 1'b0;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      win_cnt    <= 8'd0;
      red_snap   <= '0;
      black_snap <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      red_win    <= 1'b0;
      black_win  <= 1'b0;
      draw       <= 1'b0;
      win_row    <= 3'd0;
      win_col    <= 3'd0;
      win_dir    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            red_snap   <= red_cells;
            black_snap <= black_cells;
            win_cnt    <= 8'd0;
            red_win    <= 1'b0;
            black_win  <= 1'b0;
            draw       <= 1'b0;
            win_row    <= 3'd0;
            win_col    <= 3'd0;
            win_dir    <= 2'd0;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (any_match) begin
            red_win   <= red_match;
            black_win <= black_match;
            win_row   <= anchor_row;
            win_col   <= anchor_col;
            win_dir   <= dir;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else if (win_cnt == 8'(NUM_WINDOWS - 1)) begin
            draw  <= draw_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            win_cnt <= win_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          win_cnt <= 8'd0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_win_scanner.sv
// tb/tb_connect4_win_scanner.sv - self-checking bench: directed and random boards against a window-walk model
module tb_connect4_win_scanner;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [41:0] red_cells;
  logic [41:0] black_cells;
  logic        start;
  logic        busy, done, red_win, black_win, draw;
  logic [2:0]  win_row, win_col;
  logic [1:0]  win_dir;

  int total = 0;
  int bad   = 0;

  connect4_win_scanner dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .red_cells   (red_cells),
    .black_cells (black_cells),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .red_win     (red_win),
    .black_win   (black_win),
    .draw        (draw),
    .win_row     (win_row),
    .win_col     (win_col),
    .win_dir     (win_dir)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks windows in scan order on a 6x7 grid using plain row/col arithmetic.
  function automatic void model(input logic [41:0] r, input logic [41:0] b,
                                output int k_hit, output bit rw, output bit bw, output bit dr);
    bit found = 0;
    k_hit = -1; rw = 0; bw = 0; dr = 0;
    for (int k = 0; k < 168; k++) begin
      if (!found) begin
        int a = k / 4;
        int d = k % 4;
        int ar = a / 7;
        int ac = a % 7;
        int drow = (d == 0) ? 0 : 1;
        int dcol = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
        bit ok = 1, rall = 1, ball = 1;
        for (int i = 0; i < 4; i++) begin
          int rr = ar + i * drow;
          int cc = ac + i * dcol;
          if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 0;
          else begin
            if (!r[rr*7+cc]) rall = 0;
            if (!b[rr*7+cc]) ball = 0;
          end
        end
        if (ok && (rall || ball)) begin
          found = 1; k_hit = k; rw = rall; bw = ball;
        end
      end
    end
`ifdef WIN_SCAN_DRAW_EN
    if (!found) dr = &(r | b);
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " red_win"}, 32'(red_win), 0);
    check({tag, " black_win"}, 32'(black_win), 0);
    check({tag, " draw"}, 32'(draw), 0);
    check({tag, " win_rcd"}, 32'({win_row, win_col, win_dir}), 0);
  endtask

  task automatic run_scan(input logic [41:0] r, input logic [41:0] b, input bit perturb,
                          input string tag, output int cyc);
    int k; bit rw, bw, dr; bit busy_ok; bit extra_done;
    int exp_cyc;
    model(r, b, k, rw, bw, dr);
    exp_cyc = (k >= 0) ? k + 2 : 169;
    red_cells = r; black_cells = b; start = 1'b1;
    @(posedge frame_clk); #1 start = 1'b0;
    cyc = 1; busy_ok = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (perturb && cyc == 5) begin
        red_cells   = 42'({$urandom(), $urandom()});
        black_cells = 42'({$urandom(), $urandom()});
        start = 1'b1;
      end
      if (perturb && cyc == 6) start = 1'b0;
      @(posedge frame_clk); #1 cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy_during_scan"}, 32'(busy_ok), 1);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " red_win"}, 32'(red_win), 32'(rw));
    check({tag, " black_win"}, 32'(black_win), 32'(bw));
    check({tag, " draw"}, 32'(draw), 32'(dr));
    check({tag, " win_row"}, 32'(win_row), (k >= 0) ? 32'((k / 4) / 7) : 0);
    check({tag, " win_col"}, 32'(win_col), (k >= 0) ? 32'((k / 4) % 7) : 0);
    check({tag, " win_dir"}, 32'(win_dir), (k >= 0) ? 32'(k % 4) : 0);
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge frame_clk); #1;
      if (done !== 1'b0) extra_done = 1;
    end
    check({tag, " single_done"}, 32'(extra_done), 0);
    check({tag, " red_win_hold"}, 32'(red_win), 32'(rw));
  endtask

  initial begin
    int cyc;
    logic [41:0] rb, bb;
    bit saw_done;

    Reset = 1'b1; start = 1'b0; red_cells = '0; black_cells = '0;
    repeat (3) @(posedge frame_clk);
    #1 check_idle_outputs("in_reset");
    Reset = 1'b0;
    @(posedge frame_clk); #1 check_idle_outputs("after_reset");

    run_scan(42'h0, 42'h0, 0, "empty", cyc);

    run_scan(42'hF, 42'h0, 0, "red_h0", cyc);
    check("red_h0 lat2", 32'(cyc), 2);
    check("red_h0 dir", 32'({red_win, win_row, win_col, win_dir}), 32'({1'b1, 3'd0, 3'd0, 2'd0}));

    bb = '0;
    for (int rr = 2; rr < 6; rr++) bb[rr*7+6] = 1'b1;
    run_scan(42'h0, bb, 0, "black_v", cyc);
    check("black_v lat83", 32'(cyc), 83);
    check("black_v dir", 32'({black_win, win_row, win_col, win_dir}), 32'({1'b1, 3'd2, 3'd6, 2'd1}));

    run_scan(42'hF, 42'hF, 0, "both_h0", cyc);
    check("both_h0 flags", 32'({red_win, black_win}), 32'b11);

    // Column parity XOR row-pair parity: no four-in-a-row in any direction.
    rb = '0;
    for (int rr = 0; rr < 6; rr++)
      for (int cc = 0; cc < 7; cc++)
        rb[rr*7+cc] = 1'((cc % 2) ^ ((rr / 2) % 2));
    run_scan(rb, ~rb, 0, "full_draw", cyc);
`ifdef WIN_SCAN_DRAW_EN
    check("full_draw draw1", 32'(draw), 1);
`else
    check("full_draw draw0", 32'(draw), 0);
`endif

    run_scan(42'h0, 42'h0, 1, "perturb_empty", cyc);
    bb = '0;
    for (int rr = 2; rr < 6; rr++) bb[rr*7+6] = 1'b1;
    run_scan(42'h0, bb, 1, "perturb_black_v", cyc);

    // Reset mid-scan at cycle N+50.
    red_cells = '0; black_cells = '0; start = 1'b1;
    @(posedge frame_clk); #1 start = 1'b0;
    repeat (49) @(posedge frame_clk);
    #1 Reset = 1'b1;
    #1 check("midreset busy_async", 32'(busy), 0);
    @(posedge frame_clk); #1 Reset = 1'b0;
    check_idle_outputs("midreset");
    saw_done = 0;
    for (int i = 0; i < 180; i++) begin
      @(posedge frame_clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
    end
    check("midreset no_done", 32'(saw_done), 0);
    run_scan(42'hF << 7, 42'h0, 0, "post_reset", cyc);

    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0) begin
        rb = 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()});
        bb = 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()});
      end else begin
        rb = 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()});
        bb = 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()}) & 42'({$urandom(), $urandom()});
      end
      run_scan(rb, bb, n % 3 == 0, $sformatf("rand%0d", n), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/connect4_win_scanner.md
# connect4_win_scanner

Sequential win and draw detector for the Connect Four board. It reads the red and black cell-occupancy flags written by the column modules and walks every four-cell window on the 6×7 board, one window per frame_clk cycle. It reports a winner, the winning line's anchor and direction, or a draw. It sits between the column modules and the game-control and display logic, and is retriggered whenever a piece drops.

## Interface
- ROWS, 6, board rows; row 0 = bottom (row A)
- COLS, 7, board columns; col 0 = leftmost (column 1)
- frame_clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- red_cells  in  42  red occupancy, bit index = row*7 + col
- black_cells  in  42  black occupancy, same indexing
- start  in  1  one-cycle request to scan; sampled only in IDLE
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when results are valid
- red_win  out  1  red four-in-a-row found
- black_win  out  1  black four-in-a-row found
- draw  out  1  all 42 cells occupied and no win
- win_row  out  3  anchor row of the first winning window
- win_col  out  3  anchor column of the first winning window
- win_dir  out  2  0 = H (+col), 1 = V (+row), 2 = DUR (+row,+col), 3 = DUL (+row,−col)

## Operation
- States:
  - IDLE → SCAN on start.
  - SCAN → DONE when a match is found, or after window 167.
  - DONE → IDLE unconditionally.
- On start in IDLE:
  - snapshot red_cells and black_cells into internal registers;
  - clear red_win, black_win, draw, win_row, win_col and win_dir.
  - The scan uses only the snapshot; input changes during SCAN are ignored.
- Window order: window k = anchor*4 + dir.
  - Anchor runs 0..41 (row-major, as in cell indexing).
  - dir runs 0..3 within each anchor.
  - Counter is 8 bits, 0..167.
- Each window tests 4 cells from the anchor along dir.
  - A window with any cell off-board evaluates as no match and still costs one cycle.
- Match: all 4 snapshot red bits set → red_win; all 4 snapshot black bits set → black_win.
  - If both colours match in the same window, set both flags.
  - The first matching window latches win_row, win_col and win_dir, then the scan stops.
- No match after window 167:
  - red_win = black_win = 0; win_row, win_col and win_dir stay 0;
  - draw = 1 when (red|black snapshot) is all ones, else draw = 0.
- start while busy or in DONE is ignored; there is no queueing.
- Results hold from DONE until the next accepted start.
- Cell with both the red and black bit set: counted as occupied for draw, and each colour is evaluated independently.

## Timing
- Reset: state = IDLE, counter = 0, snapshot = 0. Every output is 0: busy, done, red_win, black_win, draw, win_row, win_col, win_dir.
- Start accepted in cycle N.
- busy = 1 from cycle N+1 through the last SCAN cycle.
- Window k is evaluated in cycle N+1+k.
- Match at window k: flags registered at the end of that cycle; DONE (done = 1, busy = 0) in cycle N+2+k.
- No match: DONE in cycle N+169; worst-case latency is 169 cycles.
- done is high for exactly one cycle, and busy is 0 in that cycle.
- Earliest next accepted start: cycle N+3+k (or N+170).
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0. No done pulse is produced.

## Configuration
- WIN_SCAN_DRAW_EN defined: draw is computed as specified above.
- WIN_SCAN_DRAW_EN undefined: draw is tied to 0 and the full-board reduction logic is omitted.
- Win detection, latency and all other outputs are identical in both builds.

## Structure
- Package connect4_pkg holds:
  - ROWS, COLS, NUM_CELLS = 42, NUM_WINDOWS = 168;
  - the direction enum (H, V, DUR, DUL);
  - the scanner state enum (IDLE, SCAN, DONE);
  - a cell-index function (row*COLS + col).
- Sub-module win_window_check:
  - inputs: anchor row, anchor col, dir, one 42-bit colour board;
  - outputs: in_bounds and match.
  - Purely combinational.
  - Instantiated twice, once for red and once for black.

## Test plan
- Empty board, start at N → done at N+169; red_win, black_win and draw all 0; busy high N+1..N+168.
- Red at row 0, cols 0–3 → window 0 matches; done at N+2; red_win = 1, win_row = 0, win_col = 0, win_dir = H.
- Black at col 6, rows 2–5 → anchor 20, window 81; done at N+83; black_win = 1, win_row = 2, win_col = 6, win_dir = V.
- Full board with no four-in-a-row → done at N+169, draw = 1. Same board with WIN_SCAN_DRAW_EN undefined → draw = 0.
- Start re-pulsed during SCAN, and inputs changed mid-scan → ignored; result reflects the snapshot taken at N; done fires exactly once.
- Reset pulsed at N+50 of a scan → all outputs 0 next cycle and no done pulse; a fresh start then scans normally.
